// File: rtl/instruction_memory_loadable.sv
// instruction_memory_loadable: instruction memory with registered fetch and a byte-serial program-load port
module instruction_memory_loadable #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 6,
    parameter int BYTE_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_instr,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] load_base,
    input  logic              load_valid,
    input  logic [BYTE_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              load_busy,
    output logic              load_err,
    output logic [ADDR_W:0]   word_count
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int BEATS = DATA_W / BYTE_W;
    localparam int BCW = BEATS > 1 ? $clog2(BEATS) : 1;
    typedef enum logic {IDLE, LOAD} state_t;
    state_t state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W:0] ptr;
    logic [BCW-1:0] beat;
    logic [DATA_W-1:0] asm_q, shifted, wr_word;
    logic acc, done, wr_en;
    // A short last word is left-aligned so unfilled low bytes read as zero
    always_comb begin
        acc = state == LOAD && load_valid;
        done = acc && (load_last || beat == BCW'(BEATS - 1));
        wr_en = done && !ptr[ADDR_W];
        shifted = DATA_W'({asm_q, load_data});
        wr_word = shifted << (BYTE_W * (BEATS - 1 - int'(beat)));
    end
    always_ff @(posedge clk)
        if (wr_en) mem[ptr[ADDR_W-1:0]] <= wr_word;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            fetch_valid <= 1'b0;
            fetch_instr <= '0;
            load_ready <= 1'b0;
            load_busy <= 1'b0;
            load_err <= 1'b0;
            word_count <= '0;
            ptr <= '0;
            beat <= '0;
            asm_q <= '0;
        end else if (state == IDLE) begin
            if (load_start) begin
                state <= LOAD;
                fetch_valid <= 1'b0;
                load_ready <= 1'b1;
                load_busy <= 1'b1;
                load_err <= 1'b0;
                word_count <= '0;
                ptr <= {1'b0, load_base};
                beat <= '0;
                asm_q <= '0;
            end else begin
                fetch_valid <= fetch_req;
                if (fetch_req) fetch_instr <= mem[fetch_addr];
            end
        end else begin
            fetch_valid <= 1'b0;
            if (acc) begin
                beat <= done ? '0 : beat + 1'b1;
                asm_q <= done ? '0 : shifted;
            end
            if (wr_en) begin
                ptr <= ptr + 1'b1;
                word_count <= word_count + 1'b1;
            end
            if (done && ptr[ADDR_W]) load_err <= 1'b1;
            if (acc && load_last) begin
                state <= IDLE;
                load_ready <= 1'b0;
                load_busy <= 1'b0;
            end
        end
    end
endmodule
